// File: rtl/bcd_updown_counter_if.sv
// Control and data bundle for bcd_updown_counter: count controls and load value in,
// packed BCD count, terminal count and load-error flag out.
interface bcd_updown_counter_if #(
    parameter int DIGITS = 4
);
    logic                i_en;
    logic                i_up_dn;
    logic                i_clear;
    logic                i_load;
    logic [4*DIGITS-1:0] i_load_val;
    logic [4*DIGITS-1:0] o_q;
    logic                o_tc;
    logic                o_load_err;

    modport master (
        output i_en, i_up_dn, i_clear, i_load, i_load_val,
        input  o_q, o_tc, o_load_err
    );

    modport slave (
        input  i_en, i_up_dn, i_clear, i_load, i_load_val,
        output o_q, o_tc, o_load_err
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-decade packed-BCD up/down counter with clear, checked parallel load,
// wrap/saturate end handling and a cascadable terminal-count output.
module bcd_updown_digit (
    input  logic [3:0] i_d,
    input  logic [3:0] i_ld,
    input  logic       i_up,
    input  logic       i_step,
    output logic [3:0] o_nxt,
    output logic       o_is9,
    output logic       o_is0,
    output logic       o_ld_ok
);
    assign o_is9   = (i_d == 4'd9);
    assign o_is0   = (i_d == 4'd0);
    assign o_ld_ok = (i_ld <= 4'd9);

    always_comb begin
        o_nxt = i_d;
        if (i_step) begin
            if (i_up) o_nxt = o_is9 ? 4'd0 : i_d + 4'd1;
            else      o_nxt = o_is0 ? 4'd9 : i_d - 4'd1;
        end
    end
endmodule

module bcd_updown_counter #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    bcd_updown_counter_if.slave   bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0]           r_q;
    logic                   r_load_err;
    logic [DIGITS:0]        w_lo9;
    logic [DIGITS:0]        w_lo0;
    logic [DIGITS-1:0]      w_is9;
    logic [DIGITS-1:0]      w_is0;
    logic [DIGITS-1:0]      w_ld_ok;
    logic [DIGITS-1:0]      w_step;
    logic [DIGITS-1:0][3:0] w_nxt;
    logic                   w_end;
    logic                   w_hold_end;

    // w_lo9[i]/w_lo0[i]: every digit below i is 9 / 0, i.e. carry/borrow into digit i
    assign w_lo9[0] = 1'b1;
    assign w_lo0[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            assign w_lo9[g+1] = w_lo9[g] & w_is9[g];
            assign w_lo0[g+1] = w_lo0[g] & w_is0[g];
            assign w_step[g]  = bus.i_up_dn ? w_lo9[g] : w_lo0[g];

            bcd_updown_digit u_digit (
                .i_d     (r_q[4*g +: 4]),
                .i_ld    (bus.i_load_val[4*g +: 4]),
                .i_up    (bus.i_up_dn),
                .i_step  (w_step[g]),
                .o_nxt   (w_nxt[g]),
                .o_is9   (w_is9[g]),
                .o_is0   (w_is0[g]),
                .o_ld_ok (w_ld_ok[g])
            );
        end
    endgenerate

    // At the end of the range the digit chain naturally wraps; saturate mode just holds
    assign w_end      = bus.i_up_dn ? w_lo9[DIGITS] : w_lo0[DIGITS];
    assign w_hold_end = !WRAP && w_end;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q        <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= 1'b0;
            if (bus.i_clear) begin
                r_q <= '0;
            end else if (bus.i_load) begin
                if (&w_ld_ok) r_q        <= bus.i_load_val;
                else          r_load_err <= 1'b1;
            end else if (bus.i_en && !w_hold_end) begin
                r_q <= w_nxt;
            end
        end
    end

    assign bus.o_q        = r_q;
    assign bus.o_tc       = bus.i_en & w_end;
    assign bus.o_load_err = r_load_err;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: directed vectors push expected q/tc/load_err; a monitor pops and
// compares after each clock edge. Covers wrap, saturate, load checks, priority, cascade.
module tb_bcd_updown_counter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_updown_counter_if #(.DIGITS(2)) if_w  ();
    bcd_updown_counter_if #(.DIGITS(2)) if_s  ();
    bcd_updown_counter_if #(.DIGITS(1)) if_c0 ();
    bcd_updown_counter_if #(.DIGITS(1)) if_c1 ();
    bcd_updown_counter_if #(.DIGITS(2)) if_cr ();

    bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) u_wrap (.i_clk(clk), .i_rst(rst), .bus(if_w));
    bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) u_sat  (.i_clk(clk), .i_rst(rst), .bus(if_s));
    bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) u_c0   (.i_clk(clk), .i_rst(rst), .bus(if_c0));
    bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) u_c1   (.i_clk(clk), .i_rst(rst), .bus(if_c1));
    bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) u_cr   (.i_clk(clk), .i_rst(rst), .bus(if_cr));

    assign if_c1.i_en       = if_c0.o_tc;
    assign if_c1.i_up_dn    = 1'b1;
    assign if_c1.i_clear    = 1'b0;
    assign if_c1.i_load     = 1'b0;
    assign if_c1.i_load_val = 4'h0;

    typedef struct {
        int         sel;
        logic [7:0] q;
        logic       tc;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic idle_all();
        if_w.i_en  = 1'b0; if_w.i_up_dn  = 1'b1; if_w.i_clear  = 1'b0; if_w.i_load  = 1'b0; if_w.i_load_val  = 8'h00;
        if_s.i_en  = 1'b0; if_s.i_up_dn  = 1'b1; if_s.i_clear  = 1'b0; if_s.i_load  = 1'b0; if_s.i_load_val  = 8'h00;
        if_c0.i_en = 1'b0; if_c0.i_up_dn = 1'b1; if_c0.i_clear = 1'b0; if_c0.i_load = 1'b0; if_c0.i_load_val = 4'h0;
        if_cr.i_en = 1'b0; if_cr.i_up_dn = 1'b1; if_cr.i_clear = 1'b0; if_cr.i_load = 1'b0; if_cr.i_load_val = 8'h00;
    endtask

    // Drive one cycle of stimulus on the chosen DUT and queue the post-edge expectation
    task automatic drv(input int sel, input logic en, input logic up, input logic clr,
                       input logic ld, input logic [7:0] lv,
                       input logic [7:0] eq, input logic etc, input logic eerr);
        exp_t e;
        @(negedge clk);
        idle_all();
        case (sel)
            0: begin if_w.i_en = en; if_w.i_up_dn = up; if_w.i_clear = clr; if_w.i_load = ld; if_w.i_load_val = lv; end
            1: begin if_s.i_en = en; if_s.i_up_dn = up; if_s.i_clear = clr; if_s.i_load = ld; if_s.i_load_val = lv; end
            default: begin if_c0.i_en = en; if_cr.i_en = en; end
        endcase
        e.sel = sel; e.q = eq; e.tc = etc; e.err = eerr;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0: begin
                    chk("wrap_q",   32'(if_w.o_q),        32'(e.q));
                    chk("wrap_tc",  32'(if_w.o_tc),       32'(e.tc));
                    chk("wrap_err", 32'(if_w.o_load_err), 32'(e.err));
                end
                1: begin
                    chk("sat_q",    32'(if_s.o_q),        32'(e.q));
                    chk("sat_tc",   32'(if_s.o_tc),       32'(e.tc));
                    chk("sat_err",  32'(if_s.o_load_err), 32'(e.err));
                end
                default: begin
                    chk("casc_q",   32'({if_c1.o_q, if_c0.o_q}), 32'(e.q));
                    chk("casc_ref", 32'(if_cr.o_q),              32'(e.q));
                    chk("casc_tc",  32'(if_cr.o_tc),             32'(e.tc));
                end
            endcase
        end
    end

    initial begin
        rst = 1'b1;
        idle_all();
        repeat (2) @(negedge clk);
        chk("rst_q_w",   32'(if_w.o_q), 32'h00);
        chk("rst_err_w", 32'(if_w.o_load_err), 32'h0);
        chk("rst_q_s",   32'(if_s.o_q), 32'h00);
        chk("rst_tc_w",  32'(if_w.o_tc), 32'h0);
        rst = 1'b0;

        // Up-count through the whole range and wrap
        for (int k = 1; k <= 100; k++)
            drv(0, 1, 1, 0, 0, 8'h00, bcd2(k % 100), k == 99, 0);
        for (int k = 1; k <= 3; k++)
            drv(0, 1, 1, 0, 0, 8'h00, bcd2(k), 0, 0);

        // Asynchronous reset in the middle of a cycle
        @(negedge clk);
        idle_all();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q",   32'(if_w.o_q), 32'h00);
        chk("async_rst_err", 32'(if_w.o_load_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drv(0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        drv(0, 1, 1, 0, 0, 8'h00, 8'h01, 0, 0);

        // Down-count with borrow, wrap at zero, direction reversal
        drv(0, 0, 0, 0, 1, 8'h20, 8'h20, 0, 0);
        drv(0, 1, 0, 0, 0, 8'h00, 8'h19, 0, 0);
        drv(0, 1, 0, 0, 0, 8'h00, 8'h18, 0, 0);
        drv(0, 1, 0, 0, 1, 8'h00, 8'h00, 1, 0);
        drv(0, 1, 0, 0, 0, 8'h00, 8'h99, 0, 0);
        drv(0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        drv(0, 1, 0, 0, 0, 8'h00, 8'h99, 0, 0);

        // Load validation
        drv(0, 0, 1, 0, 1, 8'h45, 8'h45, 0, 0);
        drv(0, 0, 1, 0, 1, 8'h3A, 8'h45, 0, 1);
        drv(0, 0, 1, 0, 0, 8'h00, 8'h45, 0, 0);
        drv(0, 0, 1, 0, 1, 8'h37, 8'h37, 0, 0);
        drv(0, 0, 1, 0, 1, 8'hA0, 8'h37, 0, 1);
        drv(0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0);

        // Priority: clear > load > en
        drv(0, 0, 1, 0, 1, 8'h45, 8'h45, 0, 0);
        drv(0, 1, 1, 1, 1, 8'h12, 8'h00, 0, 0);
        drv(0, 1, 1, 0, 1, 8'h12, 8'h12, 0, 0);
        drv(0, 1, 1, 1, 1, 8'hFF, 8'h00, 0, 0);
        drv(0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0);

        // Saturating instance
        drv(1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0);
        drv(1, 0, 1, 0, 1, 8'h98, 8'h98, 0, 0);
        drv(1, 1, 1, 0, 0, 8'h00, 8'h99, 1, 0);
        drv(1, 1, 1, 0, 0, 8'h00, 8'h99, 1, 0);
        drv(1, 1, 0, 0, 0, 8'h00, 8'h98, 0, 0);
        drv(1, 0, 0, 0, 1, 8'h01, 8'h01, 0, 0);
        drv(1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0);
        drv(1, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0);
        drv(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);

        // Two one-digit stages chained through tc against a two-digit reference
        for (int k = 1; k <= 100; k++)
            drv(2, 1, 1, 0, 0, 8'h00, bcd2(k % 100), k == 99, 0);

        @(negedge clk);
        idle_all();
        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
